xbus_uart: RTL and testbench

Memory-mapped transmit-only UART on the arbiter's X-bus, downstream of the arbiter and alongside the ROM/address decoder. Accepts byte writes from the CPU into a transmit FIFO, serialises them 8N1 on `txd_o` at a programmable bit rate, and exposes status and divisor registers. It is the first console output path that does not depend on the CSR output hack.

---
 rtl/xbus_uart_pkg.sv | 35 +++
 rtl/xbus_uart_sync_fifo.sv | 76 +++++++
 rtl/xbus_uart.sv | 260 ++++++++++++++++++++++++++
 tb/tb_xbus_uart.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbus_uart_pkg
// Description : Shared constants for the X-bus transmit-only UART: register
//               indices (xadr[4:3]), STATUS bit positions and the
//               transmitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package xbus_uart_pkg;

    // Register indices, decoded from xadr_i[4:3]
    localparam logic [1:0] c_REG_TXDATA  = 2'd0;
    localparam logic [1:0] c_REG_STATUS  = 2'd1;
    localparam logic [1:0] c_REG_DIVISOR = 2'd2;
    localparam logic [1:0] c_REG_RSVD    = 2'd3;

    // STATUS register layout
    localparam int c_STAT_BUSY      = 0;
    localparam int c_STAT_FULL      = 1;
    localparam int c_STAT_EMPTY     = 2;
    localparam int c_STAT_OVERRUN   = 3;
    localparam int c_STAT_IRQ_EN    = 4;
    localparam int c_STAT_COUNT_LSB = 8;
    localparam int c_STAT_COUNT_W   = 9;

    // Transmitter states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/xbus_uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, one push and one pop per cycle.
//               A push while full and a pop while empty are ignored; fullness
//               is judged on the count at the start of the cycle, so a push
//               into a full FIFO is dropped even if a pop happens alongside.
// Ports       : clk_i, reset_i (sync, active high)
//               push_i/data_i   - write side
//               pop_i/data_o    - read side, data_o shows the head entry
//               count_o, full_o, empty_o - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wptr_q, wptr_d;
    logic [c_AW-1:0]  rptr_q, rptr_d;
    logic [c_AW:0]    count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        full_o    = (count_q == (c_AW+1)'(DEPTH));
        empty_o   = (count_q == '0);
        w_do_push = push_i & ~full_o;
        w_do_pop  = pop_i & ~empty_o;
        wptr_d    = w_do_push ? wptr_q + c_AW'(1) : wptr_q;
        rptr_d    = w_do_pop  ? rptr_q + c_AW'(1) : rptr_q;
        count_d   = count_q;
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + (c_AW+1)'(1);
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says so.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/xbus_uart.sv
`default_nettype none
// ============================================================================
// Module      : xbus_uart
// Description : Memory-mapped transmit-only UART on the X-bus. CPU byte
//               writes go into a transmit FIFO and are sent 8N1 on txd_o at
//               a bit period of divisor+1 clocks.
//               Registers (xadr_i[4:3]): 0 TXDATA, 1 STATUS, 2 DIVISOR,
//               3 reserved (reads 0, writes ignored).
// Ports       : clk_i, reset_i (sync, active high)
//               xstb_i/xwe_i/xadr_i/xsiz_i/xdat_i - bus request
//               xdat_o/xack_o                     - bus response
//               txd_o                             - serial out, idle high
//               irq_o                             - transmit-complete level
//                                                   (only with macro)
// Config      : XBUS_UART_IRQ_EN - adds irq_o and the STATUS irq_en bit.
// Revision    : 1.0 - initial release
// ============================================================================
module xbus_uart
    import xbus_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        xstb_i,
    input  logic        xwe_i,
    input  logic [63:0] xadr_i,
    input  logic [1:0]  xsiz_i,
    input  logic [63:0] xdat_i,
    output logic [63:0] xdat_o,
    output logic        xack_o,
    output logic        txd_o
`ifdef XBUS_UART_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Bus side registers
    // ------------------------------------------------------------------
    logic        xack_q, xack_d;
    logic [63:0] xdat_q, xdat_d;
    logic        overrun_q, overrun_d;
    logic [15:0] div_q, div_d;

    logic [1:0]  w_reg_idx;
    logic        w_rd_go;
    logic        w_wr_go;
    logic        w_push;
    logic        w_pop;
    logic [63:0] w_status;
    logic [63:0] w_rdata;
    logic        w_irq_en;
    logic        w_busy;

    logic [7:0]         w_fifo_dout;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    // Address bits outside [4:3], the access size and the upper write data
    // carry no meaning for this peripheral.
    logic w_unused;
    assign w_unused = ^{xadr_i[63:5], xadr_i[2:0], xsiz_i, xdat_i[63:16]};

    always_comb begin
        w_reg_idx = xadr_i[4:3];
        // Read data is captured on the edge that raises ack; write side
        // effects land on the edge that ends the ack cycle.
        w_rd_go   = xstb_i & ~xack_q & ~xwe_i;
        w_wr_go   = xstb_i &  xack_q &  xwe_i;
        w_push    = w_wr_go & (w_reg_idx == c_REG_TXDATA);

        w_status                                    = '0;
        w_status[c_STAT_BUSY]                       = w_busy;
        w_status[c_STAT_FULL]                       = w_fifo_full;
        w_status[c_STAT_EMPTY]                      = w_fifo_empty;
        w_status[c_STAT_OVERRUN]                    = overrun_q;
        w_status[c_STAT_IRQ_EN]                     = w_irq_en;
        w_status[c_STAT_COUNT_LSB +: c_STAT_COUNT_W] = c_STAT_COUNT_W'(w_fifo_count);

        case (w_reg_idx)
            c_REG_STATUS:  w_rdata = w_status;
            c_REG_DIVISOR: w_rdata = {48'd0, div_q};
            default:       w_rdata = '0;
        endcase

        xack_d = xstb_i & ~xack_q;
        xdat_d = w_rd_go ? w_rdata : '0;

        overrun_d = overrun_q;
        if (w_push && w_fifo_full) begin
            overrun_d = 1'b1;
        end else if (w_wr_go && (w_reg_idx == c_REG_STATUS) && xdat_i[c_STAT_OVERRUN]) begin
            overrun_d = 1'b0;
        end

        div_d = div_q;
        if (w_wr_go && (w_reg_idx == c_REG_DIVISOR)) begin
            div_d = xdat_i[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            xack_q    <= 1'b0;
            xdat_q    <= '0;
            overrun_q <= 1'b0;
            div_q     <= DIV_RESET;
        end else begin
            xack_q    <= xack_d;
            xdat_q    <= xdat_d;
            overrun_q <= overrun_d;
            div_q     <= div_d;
        end
    end

    assign xack_o = xack_q;
    assign xdat_o = xdat_q;

    // ------------------------------------------------------------------
    // Optional transmit-complete interrupt
    // ------------------------------------------------------------------
`ifdef XBUS_UART_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (w_wr_go && (w_reg_idx == c_REG_STATUS)) begin
            irq_en_d = xdat_i[c_STAT_IRQ_EN];
        end
        irq_d = irq_en_q & w_fifo_empty & ~w_busy;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign w_irq_en = irq_en_q;
    assign irq_o    = irq_q;
`else
    assign w_irq_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .data_i  (xdat_i[7:0]),
        .pop_i   (w_pop),
        .data_o  (w_fifo_dout),
        .count_o (w_fifo_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q;
    logic [15:0] baud_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        txd_q;
    logic        w_bit_end;

    assign w_bit_end = (baud_cnt_q == 16'd0);
    assign w_busy    = (tx_state_q != TX_IDLE);
    // Taking the next byte at the end of STOP chains frames with no gap.
    assign w_pop     = ~w_fifo_empty &
                       ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & w_bit_end));

    // Every bit reloads baud_cnt_q from the divisor register, so a divisor
    // write only ever affects bits that start after it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (w_pop) begin
                        tx_state_q <= TX_START;
                        shift_q    <= w_fifo_dout;
                        baud_cnt_q <= div_q;
                        txd_q      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        tx_state_q <= TX_DATA;
                        bit_idx_q  <= 3'd0;
                        baud_cnt_q <= div_q;
                        txd_q      <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        baud_cnt_q <= div_q;
                        if (bit_idx_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        baud_cnt_q <= div_q;
                        if (w_pop) begin
                            tx_state_q <= TX_START;
                            shift_q    <= w_fifo_dout;
                            txd_q      <= 1'b0;
                        end else begin
                            tx_state_q <= TX_IDLE;
                            txd_q      <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    txd_q      <= 1'b1;
                end
            endcase
        end
    end

    assign txd_o = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_xbus_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_xbus_uart
// Description : Scoreboard bench for xbus_uart. Bus reads and serial frames
//               are queued as expectations when issued; two monitors pop and
//               compare when the DUT acks a read or completes a frame.
//               Build with XBUS_UART_IRQ_EN to cover the interrupt output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbus_uart;

    localparam int          DEPTH = 16;
    localparam logic [15:0] DIVR  = 16'd433;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        xstb = 1'b0;
    logic        xwe = 1'b0;
    logic [63:0] xadr = '0;
    logic [1:0]  xsiz = '0;
    logic [63:0] xdat_w = '0;
    logic [63:0] xdat_r;
    logic        xack;
    logic        txd;
`ifdef XBUS_UART_IRQ_EN
    logic        irq;
`endif

    xbus_uart #(
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (DIVR)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .xstb_i  (xstb),
        .xwe_i   (xwe),
        .xadr_i  (xadr),
        .xsiz_i  (xsiz),
        .xdat_i  (xdat_w),
        .xdat_o  (xdat_r),
        .xack_o  (xack),
        .txd_o   (txd)
`ifdef XBUS_UART_IRQ_EN
        ,
        .irq_o   (irq)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- reference model state ----------------
    int unsigned m_div     = 433;
    bit          m_overrun = 1'b0;
    bit          m_irq_en  = 1'b0;
    logic [63:0] rd_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_q[$];
    int unsigned last_ack_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- bus master ----------------
    task automatic bus(input bit we, input logic [1:0] idx, input logic [63:0] wd);
        int n = 0;
        @(posedge clk); #1;
        xstb   = 1'b1;
        xwe    = we;
        xadr   = {$urandom, $urandom};
        xadr[4:3] = idx;
        xsiz   = 2'($urandom_range(0, 3));
        xdat_w = wd;
        while (xack !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL bus_ack_timeout actual=no_ack required=ack");
        end
        last_ack_cyc = cyc;
        @(posedge clk); #1;
        xstb = 1'b0;
        xwe  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] idx, input logic [63:0] exp);
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        bus(1'b0, idx, {$urandom, $urandom});
    endtask

    task automatic wr_div(input int unsigned d);
        bus(1'b1, 2'd2, {$urandom, 16'(d)});
        m_div = d;
    endtask

    task automatic wr_status(input logic [15:0] v);
        bus(1'b1, 2'd1, {48'd0, v});
        if (v[3]) m_overrun = 1'b0;
`ifdef XBUS_UART_IRQ_EN
        m_irq_en = v[4];
`endif
    endtask

    // A byte is accepted unless shifter plus FIFO are already full.
    task automatic tx(input logic [7:0] b, input bit accept);
        if (accept) tx_q.push_back(b);
        else        m_overrun = 1'b1;
        bus(1'b1, 2'd0, {$urandom, 24'($urandom), b});
    endtask

    function automatic logic [63:0] idle_status();
        return 64'h4 | (m_overrun ? 64'h8 : 64'h0) | (m_irq_en ? 64'h10 : 64'h0);
    endfunction

    // ---------------- read-data monitor ----------------
    always @(negedge clk) begin
        if (!reset && xack === 1'b1 && xwe === 1'b0) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read actual=0x%0h required=none", xdat_r);
            end else begin
                check(rd_name_q.pop_front(), xdat_r, rd_q.pop_front());
            end
        end
    end

    // ---------------- serial monitor ----------------
    // Each bit must hold one level for (divisor in force at its start)+1
    // samples; ten bits form a frame checked against the expected queue.
    bit          mon_active = 1'b0;
    bit          mon_bad;
    int          mon_bit, mon_cnt, mon_len;
    logic        mon_val;
    logic [9:0]  mon_frame;
    int unsigned mon_start_cyc, mon_end_cyc;
    int          mon_gap = 0;
    int          last_gap = -1;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
            mon_gap    = 0;
        end else begin
            if (!mon_active && txd === 1'b0) begin
                mon_active    = 1'b1;
                mon_bit       = 0;
                mon_cnt       = 0;
                mon_bad       = 1'b0;
                mon_start_cyc = cyc;
                last_gap      = mon_gap;
            end
            if (mon_active) begin
                if (mon_cnt == 0) begin
                    mon_val = txd;
                    mon_len = int'(m_div) + 1;
                end else if (txd !== mon_val) begin
                    mon_bad = 1'b1;
                end
                mon_cnt++;
                if (mon_cnt == mon_len) begin
                    mon_frame[mon_bit] = mon_val;
                    mon_bit++;
                    mon_cnt = 0;
                    if (mon_bit == 10) begin
                        mon_active  = 1'b0;
                        mon_gap     = 0;
                        mon_end_cyc = cyc;
                        if (tx_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_frame actual=0x%0h required=none", mon_frame);
                        end else begin
                            check("frame", {mon_bad, mon_frame}, {1'b0, 1'b1, tx_q.pop_front(), 1'b0});
                        end
                    end
                end
            end else begin
                mon_gap++;
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || mon_active) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_frames_left required=0", tx_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!mon_active && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL start_timeout actual=idle required=frame");
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rd_q.delete();
        rd_name_q.delete();
        m_div     = 433;
        m_overrun = 1'b0;
        m_irq_en  = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_txd", {63'd0, txd}, 64'd1);
        check("reset_xack", {63'd0, xack}, 64'd0);
        check("reset_xdat", xdat_r, 64'd0);
`ifdef XBUS_UART_IRQ_EN
        check("reset_irq", {63'd0, irq}, 64'd0);
`endif
        rd("reset_status", 2'd1, 64'h4);
        rd("reset_divisor", 2'd2, 64'd433);

        // Single byte at divisor 3: start latency, bit timing, frame length
        wr_div(3);
        tx(8'h55, 1'b1);
        wait_start(20);
        check("start_latency", 64'(mon_start_cyc), 64'(last_ack_cyc + 2));
        drain(200);
        check("frame_len_div3", 64'(mon_end_cyc - mon_start_cyc + 1), 64'd40);
        rd("status_after_frame", 2'd1, idle_status());

        // Back-to-back frames must abut
        tx(8'hA5, 1'b1);
        tx(8'h3C, 1'b1);
        drain(300);
        check("no_gap_between_frames", 64'(last_gap), 64'd0);

        // Divisor change in the middle of the start bit: 4 clocks, then 8
        tx(8'h01, 1'b1);
        n = 0;
        while (txd !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        wr_div(7);
        drain(300);
        check("frame_len_div_change", 64'(mon_end_cyc - mon_start_cyc + 1), 64'(4 + 9 * 8));
        rd("divisor_7", 2'd2, 64'd7);

        // Randomized bursts with interleaved register traffic
        for (int burst = 0; burst < 5; burst++) begin
            wr_div($urandom_range(0, 3));
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                tx(b, 1'b1);
                case ($urandom_range(0, 5))
                    0: rd("rand_divisor", 2'd2, 64'(m_div));
                    1: bus(1'b1, 2'd3, {$urandom, $urandom});
                    2: rd("rand_reserved", 2'd3, 64'd0);
                    3: rd("rand_txdata", 2'd0, 64'd0);
                    default: ;
                endcase
            end
            drain(n * 60 + 100);
            rd("rand_idle_status", 2'd1, idle_status());
            rd("rand_divisor_end", 2'd2, 64'(m_div));
        end

        // Overrun: long frames so the shifter and FIFO fill deterministically
        wr_div(200);
        for (int i = 0; i < DEPTH + 2; i++) begin
            tx(8'($urandom), (i <= DEPTH));
        end
        rd("status_full_overrun", 2'd1, 64'h100B);
        wr_status(16'h0008);
        rd("status_overrun_cleared", 2'd1, 64'h1003);

        // Reset while in the data bits
        repeat (500) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_midframe_txd", {63'd0, txd}, 64'd1);
        @(posedge clk); #1 reset = 1'b0;
        rd("status_after_reset", 2'd1, 64'h4);
        rd("divisor_after_reset", 2'd2, 64'(DIVR));
        repeat (20) @(negedge clk);
        check("idle_after_reset", {63'd0, txd}, 64'd1);

`ifdef XBUS_UART_IRQ_EN
        // Transmit-complete interrupt
        wr_div(3);
        wr_status(16'h0010);
        repeat (2) @(negedge clk);
        check("irq_idle", {63'd0, irq}, 64'd1);
        rd("status_irq_en", 2'd1, 64'h14);
        tx(8'h96, 1'b1);
        wait_start(20);
        @(negedge clk);
        check("irq_busy", {63'd0, irq}, 64'd0);
        drain(200);
        @(negedge clk);
        check("irq_done", {63'd0, irq}, 64'd1);
`endif

        repeat (5) @(posedge clk);
        checks++;
        if (rd_q.size() != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations actual=%0d required=0", rd_q.size() + tx_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
